alu_control_unit: RTL and testbench
===================================

Name: alu_control_unit

Overview:
- Fetch/decode/sequence controller directly upstream of the ALU.
- Fetches 16-bit instructions from a synchronous-read instruction ROM and decodes them.
- Drives the ALU `operation`/`shift` codes and the register-file A/B read selects.
- Commits ALU `C_bus` results via a register-file write strobe; resolves conditional jumps using the ALU `z_flag`.

Parameters:
- PC_WIDTH, 8, width of program counter and instruction-ROM address.
- RESET_PC, 0, PC value loaded on reset and on start.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins execution from RESET_PC when idle.
- imem_addr  output  PC_WIDTH  instruction-ROM address (= pc).
- imem_data  input  16  ROM read data, valid one cycle after imem_addr.
- z_flag  input  1  ALU zero flag.
- operation  output  3  ALU op code.
- shift  output  4  ALU shift amount.
- a_sel  output  4  register-file select driving A_bus.
- b_sel  output  4  register-file select driving B_bus.
- c_dst  output  4  register-file write address for C_bus.
- c_wr_en  output  1  register-file write strobe for C_bus.
- busy  output  1  high in any state other than IDLE/HALT.
- done  output  1  high while in HALT.
- illegal  output  1  illegal-opcode trap flag (see Optional Feature).

Behaviour:
- Instruction fields: [15:12] opcode, [11:8] dst, [7:4] srcA, [3:0] srcB/shift.
  - Jump target is [PC_WIDTH-1:0].
- Opcodes 1–7 map directly to the ALU codes: ADD=1, SUB=2, INC=3, DEC=4, LSHIFT=5, RSHIFT=6, CLR=7.
- Other opcodes:
  - 0 NOP.
  - 8 JMP.
  - 9 JMPZ (jump if z_flag=1).
  - 10 JMPNZ (jump if z_flag=0).
  - 15 HALT.
  - 11–14 reserved.
- Reset (rst=1 at clock edge, from any state, including mid-instruction):
  - state=IDLE, pc=RESET_PC, IR=0.
  - operation=000, shift=0, a_sel=b_sel=c_dst=0.
  - c_wr_en=0, busy=0, done=0, illegal=0.
  - Reset never issues ALU code 111.
- States:
  - IDLE: outputs quiescent. start=1 -> pc<=RESET_PC, go to FETCH.
  - FETCH: imem_addr=pc -> DECODE.
  - DECODE: IR<=imem_data -> EXEC.
  - EXEC:
    - ALU opcode: operation=IR[14:12], a_sel=srcA, b_sel=srcB, shift=IR[3:0]. The ALU registers its result at the end of this cycle. Next state WB.
    - JMP: pc<=target -> FETCH.
    - JMPZ/JMPNZ taken: pc<=target -> FETCH. Not taken: pc<=pc+1 -> FETCH.
    - NOP/reserved: pc<=pc+1 -> FETCH.
    - HALT: go to HALT.
  - WB: c_wr_en=1 for exactly this cycle, c_dst=IR dst; pc<=pc+1 -> FETCH.
  - HALT: done=1; stays until rst. start is ignored.
- operation is 000 in every cycle except EXEC of an ALU opcode, so the ALU holds C_bus and z_flag.
- Latency:
  - ALU instruction: 4 cycles.
  - Jump/NOP: 3 cycles.
  - start->first imem_addr: 1 cycle.
- z_flag is sampled in EXEC only. It reflects the most recent SUB or DEC, since the ALU updates it only on those ops. A SUB immediately followed by JMPZ sees the new flag.
- pc+1 wraps modulo 2^PC_WIDTH (0xFF -> 0x00 at default); no error.
- start while busy or in HALT: ignored.
- start and rst in the same cycle: rst wins.
- a_sel/b_sel/shift may hold stale values outside EXEC; only c_wr_en qualifies writes.

Optional Feature:
- Macro CU_ILLEGAL_TRAP_EN.
- Defined: opcodes 11–14 in EXEC go to HALT with illegal=1 and done=1; pc is left pointing at the offending instruction. Both flags clear only on rst.
- Undefined: opcodes 11–14 behave as NOP, and illegal is tied 0.

Test Plan:
- rst held 2 cycles, then start; ROM[0]=0x1312 (ADD r3=r1+r2) -> imem_addr=0 one cycle after start. EXEC cycle shows operation=001, a_sel=1, b_sel=2. Next cycle c_wr_en=1, c_dst=3. Then imem_addr=1.
- ROM: 0x2455 (SUB r4=r5-r5), 0x9020 (JMPZ 0x20) -> pc becomes 0x20 after the jump; no c_wr_en during jump. Repeat with r5≠r6 operands -> pc=2.
- ROM[0]=0x6710 (RSHIFT r7=r1>>0), ROM[1]=0x6A13 -> second EXEC drives operation=110, shift=3; c_dst=0xA.
- pc=0xFF holding 0x1000 (ADD) -> after WB, imem_addr=0x00.
- ROM[2]=0xF000 -> done=1 and busy=0 from the cycle after EXEC; start pulses ignored; rst returns to IDLE with done=0.
- rst asserted during WB -> c_wr_en=0 next cycle, pc=RESET_PC; with CU_ILLEGAL_TRAP_EN, opcode 0xB000 at pc=5 gives illegal=1, done=1, imem_addr=5.

Source files
------------

// File: rtl/alu_control_unit_if.sv
// ---------------------------------------------------------------------------
// alu_control_unit_if
//   Bundles the controller's instruction-ROM port and its ALU/register-file
//   control bus into one interface.
//
//   master (controller side):
//     imem_addr [PC_WIDTH] out  instruction-ROM address
//     imem_data [16]       in   ROM read data, valid one cycle after imem_addr
//     z_flag               in   ALU zero flag
//     operation [3]        out  ALU op code
//     shift     [4]        out  ALU shift amount
//     a_sel     [4]        out  register-file select for A_bus
//     b_sel     [4]        out  register-file select for B_bus
//     c_dst     [4]        out  register-file write address for C_bus
//     c_wr_en              out  register-file write strobe
//   slave (ROM/ALU/register-file side): same signals, opposite directions.
// ---------------------------------------------------------------------------
interface alu_control_unit_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_data;
    logic                z_flag;
    logic [2:0]          operation;
    logic [3:0]          shift;
    logic [3:0]          a_sel;
    logic [3:0]          b_sel;
    logic [3:0]          c_dst;
    logic                c_wr_en;

    modport master (
        output imem_addr, operation, shift, a_sel, b_sel, c_dst, c_wr_en,
        input  imem_data, z_flag
    );

    modport slave (
        input  imem_addr, operation, shift, a_sel, b_sel, c_dst, c_wr_en,
        output imem_data, z_flag
    );
endinterface

// File: rtl/alu_control_unit.sv
// ---------------------------------------------------------------------------
// alu_control_unit
//   Fetch/decode/sequence controller sitting directly upstream of the ALU.
//   Fetches 16-bit instructions from a synchronous-read ROM, drives the ALU
//   operation/shift codes and register-file selects, commits C_bus results
//   through a one-cycle write strobe and resolves conditional jumps on z_flag.
//
//   Instruction: [15:12] opcode, [11:8] dst, [7:4] srcA, [3:0] srcB/shift,
//                jump target = [PC_WIDTH-1:0].
//   Opcodes: 0 NOP, 1-7 ALU (ADD SUB INC DEC LSHIFT RSHIFT CLR), 8 JMP,
//            9 JMPZ, 10 JMPNZ, 11-14 reserved, 15 HALT.
//
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   synchronous active-high reset
//     start    in   one-cycle pulse, begins execution at RESET_PC from IDLE
//     bus      --   alu_control_unit_if.master (ROM port + ALU control bus)
//     busy     out  high in any state other than IDLE/HALT
//     done     out  high while in HALT
//     illegal  out  illegal-opcode trap flag
//
//   Build option: define CU_ILLEGAL_TRAP_EN to trap reserved opcodes 11-14
//   into HALT with illegal=1. Without it they execute as NOP and illegal=0.
// ---------------------------------------------------------------------------
module alu_control_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    alu_control_unit_if.master        bus,
    output logic                      busy,
    output logic                      done,
    output logic                      illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_INC    = 4'd3;
    localparam logic [3:0] OP_DEC    = 4'd4;
    localparam logic [3:0] OP_LSHIFT = 4'd5;
    localparam logic [3:0] OP_RSHIFT = 4'd6;
    localparam logic [3:0] OP_CLR    = 4'd7;
    localparam logic [3:0] OP_JMP    = 4'd8;
    localparam logic [3:0] OP_JMPZ   = 4'd9;
    localparam logic [3:0] OP_JMPNZ  = 4'd10;
    localparam logic [3:0] OP_HALT   = 4'd15;

    state_t              state;
    state_t              state_nxt;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] target;
    logic [15:0]         ir;
    logic [3:0]          opcode;
    logic                illegal_q;
    logic                illegal_nxt;

    assign opcode = ir[15:12];
    assign target = ir[PC_WIDTH-1:0];
    // Wraps modulo 2^PC_WIDTH by construction.
    assign pc_inc = pc + PC_WIDTH'(1);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            illegal_q <= illegal_nxt;
            if (state == S_DECODE) begin
                ir <= bus.imem_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and control outputs
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case statements can leave a latch behind.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        illegal_nxt   = illegal_q;
        bus.operation = 3'b000;
        bus.c_wr_en   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_nxt    = RESET_PC;
                    state_nxt = S_FETCH;
                end
            end

            S_FETCH:  state_nxt = S_DECODE;

            S_DECODE: state_nxt = S_EXEC;

            S_EXEC: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_ADD, OP_SUB, OP_INC, OP_DEC,
                    OP_LSHIFT, OP_RSHIFT, OP_CLR: begin
                        // ALU codes equal the low three opcode bits.
                        bus.operation = ir[14:12];
                        state_nxt     = S_WB;
                    end
                    OP_JMP:   pc_nxt = target;
                    OP_JMPZ:  pc_nxt = bus.z_flag ? target : pc_inc;
                    OP_JMPNZ: pc_nxt = bus.z_flag ? pc_inc : target;
                    OP_HALT:  state_nxt = S_HALT;
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        // Reserved opcodes stop the machine with pc still
                        // pointing at the offending instruction.
                        if (opcode != OP_NOP) begin
                            state_nxt   = S_HALT;
                            illegal_nxt = 1'b1;
                        end else begin
                            pc_nxt = pc_inc;
                        end
`else
                        pc_nxt = pc_inc;
`endif
                    end
                endcase
            end

            S_WB: begin
                bus.c_wr_en = 1'b1;
                pc_nxt      = pc_inc;
                state_nxt   = S_FETCH;
            end

            S_HALT: ;   // left only through rst; start is ignored

            default: state_nxt = S_IDLE;
        endcase
    end

    // Field selects follow IR directly; they may be stale outside EXEC/WB,
    // since operation and c_wr_en alone qualify the ALU and the write.
    assign bus.imem_addr = pc;
    assign bus.a_sel     = ir[7:4];
    assign bus.b_sel     = ir[3:0];
    assign bus.shift     = ir[3:0];
    assign bus.c_dst     = ir[11:8];

    assign busy = (state != S_IDLE) && (state != S_HALT);
    assign done = (state == S_HALT);

`ifdef CU_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_control_unit
//   Drives alu_control_unit with directed and random ROM programs. The bench
//   owns the ROM, a small ALU and register file. An instruction-level model
//   interprets each program and queues the expected ALU issues, write-backs
//   and halt; a monitor pops and compares whenever the DUT shows one.
// ---------------------------------------------------------------------------
module tb_alu_control_unit;

    localparam int PW     = 8;
    localparam int BUDGET = 400;

    typedef enum logic [1:0] { EV_ALU, EV_WB, EV_HALT } ev_kind_t;

    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] pc;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sh;
        logic [3:0] dst;
        logic       ill;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic illegal;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    ev_t exp_q[$];

    logic [15:0] rom [256];
    logic [15:0] rom_q;
    logic [7:0]  rf [16];
    logic [7:0]  c_q;
    logic        z_q;
    logic        dp_load;
    logic [7:0]  dp_seed [16];
    logic [7:0]  m_rf [16];
    logic        m_z;

    alu_control_unit_if #(.PC_WIDTH(PW)) bus ();

    alu_control_unit #(
        .PC_WIDTH (PW),
        .RESET_PC (8'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus.master),
        .busy    (busy),
        .done    (done),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ ALU maths
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [3:0] sh);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a + 8'd1;
            3'd4:    return a - 8'd1;
            3'd5:    return a << sh;
            3'd6:    return a >> sh;
            3'd7:    return 8'd0;
            default: return a;
        endcase
    endfunction

    // ------------------------------------- environment: ROM, ALU, reg file
    always @(posedge clk) rom_q <= rom[bus.imem_addr];
    assign bus.imem_data = rom_q;
    assign bus.z_flag    = z_q;

    always @(posedge clk) begin
        if (dp_load) begin
            for (int i = 0; i < 16; i++) rf[i] <= dp_seed[i];
            z_q <= 1'b0;
            c_q <= 8'd0;
        end else begin
            if (bus.operation != 3'd0) begin
                c_q <= alu_fn(bus.operation, rf[bus.a_sel], rf[bus.b_sel], bus.shift);
                if (bus.operation == 3'd2 || bus.operation == 3'd4)
                    z_q <= (alu_fn(bus.operation, rf[bus.a_sel], rf[bus.b_sel], bus.shift) == 8'd0);
            end
            if (bus.c_wr_en) rf[bus.c_dst] <= c_q;
        end
    end

    // ------------------------------------------------------------ checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic take(input ev_kind_t k, output ev_t e, output bit ok);
        e  = '0;
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: actual kind=%0d required=none", k);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            ok = (k == e.kind);
        end
    endtask

    // Instruction-level interpreter: walks the program from pc 0 and queues
    // every externally visible event in order.
    task automatic run_model(input int max_instr, output bit halted, output bit halt_ill);
        logic [7:0]  pc;
        logic [15:0] ins;
        logic [3:0]  opc;
        logic [7:0]  res;
        ev_t         e;
        pc       = 8'h00;
        halted   = 1'b0;
        halt_ill = 1'b0;
        for (int n = 0; n < max_instr && !halted; n++) begin
            ins    = rom[pc];
            opc    = ins[15:12];
            e      = '0;
            e.pc   = pc;
            if (opc >= 4'd1 && opc <= 4'd7) begin
                e.kind = EV_ALU;
                e.op   = opc[2:0];
                e.a    = ins[7:4];
                e.b    = ins[3:0];
                e.sh   = ins[3:0];
                exp_q.push_back(e);
                res = alu_fn(opc[2:0], m_rf[ins[7:4]], m_rf[ins[3:0]], ins[3:0]);
                if (opc == 4'd2 || opc == 4'd4) m_z = (res == 8'd0);
                m_rf[ins[11:8]] = res;
                e.kind = EV_WB;
                e.dst  = ins[11:8];
                exp_q.push_back(e);
                pc = pc + 8'd1;
            end else if (opc == 4'd8) begin
                pc = ins[7:0];
            end else if (opc == 4'd9) begin
                pc = m_z ? ins[7:0] : pc + 8'd1;
            end else if (opc == 4'd10) begin
                pc = m_z ? pc + 8'd1 : ins[7:0];
            end else if (opc == 4'd15) begin
                e.kind = EV_HALT;
                exp_q.push_back(e);
                halted = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
            end else if (opc != 4'd0) begin
                e.kind = EV_HALT;
                e.ill  = 1'b1;
                exp_q.push_back(e);
                halted   = 1'b1;
                halt_ill = 1'b1;
`endif
            end else begin
                pc = pc + 8'd1;
            end
        end
    endtask

    // Monitor: compares each DUT event against the head of the queue.
    initial begin : monitor
        bit         wb_follow;
        bit         prev_done;
        bit         ok;
        logic [7:0] wb_pc;
        ev_t        e;
        wb_follow = 1'b0;
        prev_done = 1'b0;
        wb_pc     = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!armed) begin
                wb_follow = 1'b0;
            end else begin
                if (wb_follow) begin
                    check("pc_after_wb", 32'(bus.imem_addr), 32'(8'(wb_pc + 8'd1)));
                    wb_follow = 1'b0;
                end
                if (bus.operation != 3'd0) begin
                    take(EV_ALU, e, ok);
                    if (ok) begin
                        check("alu_pc", 32'(bus.imem_addr), 32'(e.pc));
                        check("alu_operation", 32'(bus.operation), 32'(e.op));
                        check("alu_a_sel", 32'(bus.a_sel), 32'(e.a));
                        check("alu_b_sel", 32'(bus.b_sel), 32'(e.b));
                        check("alu_shift", 32'(bus.shift), 32'(e.sh));
                    end
                end
                if (bus.c_wr_en) begin
                    take(EV_WB, e, ok);
                    if (ok) begin
                        check("wb_pc", 32'(bus.imem_addr), 32'(e.pc));
                        check("wb_c_dst", 32'(bus.c_dst), 32'(e.dst));
                    end
                    wb_follow = 1'b1;
                    wb_pc     = bus.imem_addr;
                end
                if (done && !prev_done) begin
                    take(EV_HALT, e, ok);
                    if (ok) begin
                        check("halt_pc", 32'(bus.imem_addr), 32'(e.pc));
                        check("halt_illegal", 32'(illegal), 32'(e.ill));
                        check("halt_busy", 32'(busy), 0);
                    end
                end
            end
            prev_done = done;
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic check_quiescent(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_illegal"}, 32'(illegal), 0);
        check({tag, "_imem_addr"}, 32'(bus.imem_addr), 0);
        check({tag, "_operation"}, 32'(bus.operation), 0);
        check({tag, "_c_wr_en"}, 32'(bus.c_wr_en), 0);
        check({tag, "_sel"}, 32'({bus.a_sel, bus.b_sel, bus.c_dst, bus.shift}), 0);
    endtask

    task automatic reset_dut();
        armed = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_quiescent("reset");
    endtask

    task automatic fill_rom(input logic [15:0] val);
        for (int i = 0; i < 256; i++) rom[i] = val;
    endtask

    task automatic seed_regs();
        for (int i = 0; i < 16; i++) dp_seed[i] = 8'($urandom_range(0, 3));
    endtask

    task automatic load_regs();
        for (int i = 0; i < 16; i++) m_rf[i] = dp_seed[i];
        m_z     = 1'b0;
        dp_load = 1'b1;
        @(negedge clk);
        dp_load = 1'b0;
    endtask

    task automatic run_program(input int max_instr);
        bit         halted;
        bit         halt_ill;
        int         n;
        logic [7:0] hold;
        load_regs();
        exp_q.delete();
        run_model(max_instr, halted, halt_ill);
        armed = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_imem_addr", 32'(bus.imem_addr), 0);
        n = 0;
        while (exp_q.size() != 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: actual pending=%0d required=0", exp_q.size());
        end
        @(negedge clk);
        if (halted) begin
            hold  = bus.imem_addr;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check("halt_hold_done", 32'(done), 1);
            check("halt_hold_busy", 32'(busy), 0);
            check("halt_hold_addr", 32'(bus.imem_addr), 32'(hold));
            check("halt_hold_illegal", 32'(illegal), 32'(halt_ill));
        end
        for (int i = 0; i < 16; i++) check("regfile", 32'(rf[i]), 32'(m_rf[i]));
        reset_dut();
    endtask

    task automatic gen_random_rom();
        logic [15:0] ins;
        for (int i = 0; i < 256; i++) begin
            ins = 16'($urandom());
            if (ins[15:12] == 4'd2 && $urandom_range(0, 1) == 1) ins[3:0] = ins[7:4];
            rom[i] = ins;
        end
    endtask

    initial begin : driver
        int n;
        bit halted;
        bit halt_ill;
        rst     = 1'b1;
        start   = 1'b0;
        dp_load = 1'b0;
        fill_rom(16'hF000);
        repeat (2) @(negedge clk);
        check_quiescent("power_on");

        // rst and start together: rst wins
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_quiescent("rst_start");

        // ADD r3 = r1 + r2, then HALT
        fill_rom(16'hF000);
        rom[0] = 16'h1312;
        seed_regs();
        run_program(8);

        // SUB r4 = r5 - r5 -> JMPZ taken to 0x20
        fill_rom(16'hF000);
        rom[0] = 16'h2455;
        rom[1] = 16'h9020;
        seed_regs();
        run_program(8);

        // SUB r4 = r5 - r6 with r5 != r6 -> JMPZ falls through to pc 2
        fill_rom(16'hF000);
        rom[0] = 16'h2456;
        rom[1] = 16'h9020;
        seed_regs();
        dp_seed[6] = dp_seed[5] + 8'd1;
        run_program(8);

        // Two right shifts
        fill_rom(16'hF000);
        rom[0] = 16'h6710;
        rom[1] = 16'h6A13;
        seed_regs();
        run_program(8);

        // ADD at 0xFF: pc wraps to 0x00 after write-back
        fill_rom(16'hF000);
        rom[0]     = 16'h80FF;
        rom[8'hFF] = 16'h1000;
        seed_regs();
        run_program(3);

        // Reserved opcode at pc 5
        fill_rom(16'hF000);
        for (int i = 0; i < 5; i++) rom[i] = 16'h0000;
        rom[5] = 16'hB000;
        seed_regs();
        run_program(10);

        // rst during write-back
        fill_rom(16'hF000);
        rom[0] = 16'h1312;
        seed_regs();
        load_regs();
        exp_q.delete();
        run_model(1, halted, halt_ill);
        armed = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!bus.c_wr_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_wb_reached", 32'(bus.c_wr_en), 1);
        armed = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_wb_c_wr_en", 32'(bus.c_wr_en), 0);
        check("rst_wb_imem_addr", 32'(bus.imem_addr), 0);
        check("rst_wb_busy", 32'(busy), 0);
        check("rst_wb_queue", 32'(exp_q.size()), 0);

        // Random programs
        for (int t = 0; t < 25; t++) begin
            gen_random_rom();
            seed_regs();
            run_program(40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
